// File: rtl/gpu_pkg.sv
// Shared widths, screen defaults and the setup FSM encoding for the
// triangle front end.
package gpu_pkg;
  localparam int SCREEN_W_DEF = 320;
  localparam int SCREEN_H_DEF = 240;

  localparam int X_W       = 9;
  localparam int Y_W       = 8;
  localparam int Z_W       = 16;
  localparam int COL_W     = 8;
  localparam int INV_W     = 32;
  localparam int COEF_W    = 10;
  localparam int PROD_W    = X_W + Y_W;
  localparam int CONST_W   = PROD_W + 1;
  localparam int AREA_W    = 21;
  localparam int NUM_EDGES = 3;

  typedef enum logic [3:0] {
    IDLE, EDGE, CEQ, AREA_MUL, AREA, ORIENT, START, WAIT_R, DONE
  } setup_state_e;
endpackage

// File: rtl/edge_coeff.sv
// One edge equation a*x + b*y + c for the directed edge vj->vk; the two
// cross products are registered so c lands one cycle after a and b.
module edge_coeff
  import gpu_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      calc,
  input  logic                      flip,
  input  logic [X_W-1:0]            xj,
  input  logic [Y_W-1:0]            yj,
  input  logic [X_W-1:0]            xk,
  input  logic [Y_W-1:0]            yk,
  output logic signed [COEF_W-1:0]  a,
  output logic signed [COEF_W-1:0]  b,
  output logic signed [CONST_W-1:0] c
);
  logic [PROD_W-1:0] p_jk, p_kj;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a    <= '0;
      b    <= '0;
      c    <= '0;
      p_jk <= '0;
      p_kj <= '0;
    end else if (load) begin
      a    <= $signed({{(COEF_W-Y_W){1'b0}}, yj}) - $signed({{(COEF_W-Y_W){1'b0}}, yk});
      b    <= $signed({{(COEF_W-X_W){1'b0}}, xk}) - $signed({{(COEF_W-X_W){1'b0}}, xj});
      p_jk <= {{Y_W{1'b0}}, xj} * {{X_W{1'b0}}, yk};
      p_kj <= {{Y_W{1'b0}}, xk} * {{X_W{1'b0}}, yj};
    end else if (calc) begin
      c <= $signed({1'b0, p_jk}) - $signed({1'b0, p_kj});
    end else if (flip) begin
      a <= -a;
      b <= -b;
      c <= -c;
    end
  end
endmodule

// File: rtl/triangle_setup.sv
// Triangle setup: captures a screen-space triangle, derives its edge
// equations, clipped bounding box and winding, then hands it to the rasterizer.
module triangle_setup
  import gpu_pkg::*;
#(
  parameter int SCREEN_W      = SCREEN_W_DEF,
  parameter int SCREEN_H      = SCREEN_H_DEF,
  parameter int CULL_BACKFACE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tri_valid,
  output logic                      tri_ready,
  input  logic [X_W-1:0]            vx1, vx2, vx3,
  input  logic [Y_W-1:0]            vy1, vy2, vy3,
  input  logic [Z_W-1:0]            vz1, vz2, vz3,
  input  logic [COL_W-1:0]          color_in,
  input  logic [INV_W-1:0]          inv_area_in,
  output logic signed [COEF_W-1:0]  a1, b1, a2, b2, a3, b3,
  output logic signed [CONST_W-1:0] c1, c2, c3,
  output logic [X_W-1:0]            bbxi, bbxf,
  output logic [Y_W-1:0]            bbyi, bbyf,
  output logic [Z_W-1:0]            z1, z2, z3,
  output logic [COL_W-1:0]          color,
  output logic [INV_W-1:0]          inv_area,
  output logic                      rasterizer_start,
  input  logic                      rasterizer_done,
  output logic                      setup_done,
  output logic                      culled
);
  localparam logic [X_W-1:0] X_LIM = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(SCREEN_H - 1);

  setup_state_e state;
  logic [NUM_EDGES-1:0][X_W-1:0]     vx;
  logic [NUM_EDGES-1:0][Y_W-1:0]     vy;
  logic [NUM_EDGES-1:0][COEF_W-1:0]  ea, eb;
  logic [NUM_EDGES-1:0][CONST_W-1:0] ec;
  logic signed [AREA_W-1:0]          m_x, m_y, area2, c_ext;
  logic [X_W-1:0] xmin, xmax, xmax_c;
  logic [Y_W-1:0] ymin, ymax, ymax_c;
  logic bb_cull, area_pos, area_neg, rasterize, edge_flip;

  // Edge i is the edge opposite vertex i.
  for (genvar i = 0; i < NUM_EDGES; i++) begin : g_edge
    localparam int J = (i + 1) % NUM_EDGES;
    localparam int K = (i + 2) % NUM_EDGES;
    edge_coeff u_edge (
      .clk  (clk),
      .rst  (rst),
      .load (state == EDGE),
      .calc (state == CEQ),
      .flip (edge_flip),
      .xj   (vx[J]),
      .yj   (vy[J]),
      .xk   (vx[K]),
      .yk   (vy[K]),
      .a    (ea[i]),
      .b    (eb[i]),
      .c    (ec[i])
    );
  end

  assign a1 = ea[0]; assign b1 = eb[0]; assign c1 = ec[0];
  assign a2 = ea[1]; assign b2 = eb[1]; assign c2 = ec[1];
  assign a3 = ea[2]; assign b3 = eb[2]; assign c3 = ec[2];

  always_comb begin
    xmin = vx[0];
    xmax = vx[0];
    ymin = vy[0];
    ymax = vy[0];
    for (int i = 1; i < NUM_EDGES; i++) begin
      if (vx[i] < xmin) xmin = vx[i];
      if (vx[i] > xmax) xmax = vx[i];
      if (vy[i] < ymin) ymin = vy[i];
      if (vy[i] > ymax) ymax = vy[i];
    end
    xmax_c = (xmax > X_LIM) ? X_LIM : xmax;
    ymax_c = (ymax > Y_LIM) ? Y_LIM : ymax;
  end

  assign c_ext     = {{(AREA_W-CONST_W){ec[0][CONST_W-1]}}, ec[0]};
  assign area_neg  = area2[AREA_W-1];
  assign area_pos  = !area_neg && (area2 != '0);
  assign rasterize = !bb_cull && (area_pos || (area_neg && (CULL_BACKFACE == 0)));
  // Clockwise triangles are rewound in place so the rasterizer only sees one winding.
  assign edge_flip = (state == ORIENT) && !bb_cull && area_neg && (CULL_BACKFACE == 0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      tri_ready        <= 1'b0;
      vx               <= '0;
      vy               <= '0;
      z1               <= '0;
      z2               <= '0;
      z3               <= '0;
      color            <= '0;
      inv_area         <= '0;
      bbxi             <= '0;
      bbxf             <= '0;
      bbyi             <= '0;
      bbyf             <= '0;
      bb_cull          <= 1'b0;
      m_x              <= '0;
      m_y              <= '0;
      area2            <= '0;
      rasterizer_start <= 1'b0;
      setup_done       <= 1'b0;
      culled           <= 1'b0;
    end else begin
      rasterizer_start <= 1'b0;
      setup_done       <= 1'b0;
      case (state)
        IDLE: begin
          tri_ready <= 1'b1;
          if (tri_valid && tri_ready) begin
            vx        <= {vx3, vx2, vx1};
            vy        <= {vy3, vy2, vy1};
            z1        <= vz1;
            z2        <= vz2;
            z3        <= vz3;
            color     <= color_in;
            inv_area  <= inv_area_in;
            culled    <= 1'b0;
            tri_ready <= 1'b0;
            state     <= EDGE;
          end
        end
        EDGE: state <= CEQ;
        CEQ: begin
          bbxi    <= xmin;
          bbxf    <= xmax_c;
          bbyi    <= ymin;
          bbyf    <= ymax_c;
          bb_cull <= (xmin > xmax_c) || (ymin > ymax_c);
          state   <= AREA_MUL;
        end
        AREA_MUL: begin
          m_x   <= $signed({{(AREA_W-COEF_W){ea[0][COEF_W-1]}}, ea[0]})
                 * $signed({{(AREA_W-X_W){1'b0}}, vx[0]});
          m_y   <= $signed({{(AREA_W-COEF_W){eb[0][COEF_W-1]}}, eb[0]})
                 * $signed({{(AREA_W-Y_W){1'b0}}, vy[0]});
          state <= AREA;
        end
        AREA: begin
          area2 <= m_x + m_y + c_ext;
          state <= ORIENT;
        end
        ORIENT: begin
          if (rasterize) state <= START;
          else begin
            culled <= 1'b1;
            state  <= DONE;
          end
        end
        START: begin
          rasterizer_start <= 1'b1;
          state            <= WAIT_R;
        end
        WAIT_R: if (rasterizer_done) state <= DONE;
        DONE: begin
          setup_done <= 1'b1;
          tri_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_triangle_setup.sv
// Randomised and directed bench for triangle_setup against a plain
// arithmetic model of edge equations, winding and clipped bounding box.
module tb_triangle_setup;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              tri_valid = 1'b0, tri_ready;
  logic [8:0]        vx1 = '0, vx2 = '0, vx3 = '0;
  logic [7:0]        vy1 = '0, vy2 = '0, vy3 = '0;
  logic [15:0]       vz1 = '0, vz2 = '0, vz3 = '0;
  logic [7:0]        color_in = '0;
  logic [31:0]       inv_area_in = '0;
  logic signed [9:0] a1, b1, a2, b2, a3, b3;
  logic signed [17:0] c1, c2, c3;
  logic [8:0]        bbxi, bbxf;
  logic [7:0]        bbyi, bbyf;
  logic [15:0]       z1, z2, z3;
  logic [7:0]        color;
  logic [31:0]       inv_area;
  logic              rasterizer_start, setup_done, culled;
  logic              rasterizer_done = 1'b0;

  triangle_setup dut (
    .clk(clk), .rst(rst), .tri_valid(tri_valid), .tri_ready(tri_ready),
    .vx1(vx1), .vx2(vx2), .vx3(vx3), .vy1(vy1), .vy2(vy2), .vy3(vy3),
    .vz1(vz1), .vz2(vz2), .vz3(vz3), .color_in(color_in), .inv_area_in(inv_area_in),
    .a1(a1), .b1(b1), .a2(a2), .b2(b2), .a3(a3), .b3(b3), .c1(c1), .c2(c2), .c3(c3),
    .bbxi(bbxi), .bbxf(bbxf), .bbyi(bbyi), .bbyf(bbyf),
    .z1(z1), .z2(z2), .z3(z3), .color(color), .inv_area(inv_area),
    .rasterizer_start(rasterizer_start), .rasterizer_done(rasterizer_done),
    .setup_done(setup_done), .culled(culled)
  );

  int n_cmp = 0, n_bad = 0;
  int tx[3], ty[3], tz[3], tcol;
  logic [31:0] tinv;
  int exp_a[3], exp_b[3], exp_c[3], exp_area, exp_bb[4];
  bit exp_rast;
  int start_cyc, n_start, done_cyc;
  bit got_done, cul_at_start, cul_at_done;
  int sa[3], sb[3], sc[3], sbb[4], sz[3], scol;
  int da[3], db[3], dc[3], dbb[4];
  logic [31:0] sinv;

  // Reference: twice the signed area by cross product, edges from vertex
  // differences, bbox by min/max clipped to the 320x240 screen.
  task automatic model();
    int j, k;
    bit bb_bad;
    exp_area = (tx[1]-tx[0])*(ty[2]-ty[0]) - (tx[2]-tx[0])*(ty[1]-ty[0]);
    exp_bb[0] = tx[0]; exp_bb[1] = tx[0]; exp_bb[2] = ty[0]; exp_bb[3] = ty[0];
    for (int i = 1; i < 3; i++) begin
      if (tx[i] < exp_bb[0]) exp_bb[0] = tx[i];
      if (tx[i] > exp_bb[1]) exp_bb[1] = tx[i];
      if (ty[i] < exp_bb[2]) exp_bb[2] = ty[i];
      if (ty[i] > exp_bb[3]) exp_bb[3] = ty[i];
    end
    if (exp_bb[1] > 319) exp_bb[1] = 319;
    if (exp_bb[3] > 239) exp_bb[3] = 239;
    bb_bad = (exp_bb[0] > exp_bb[1]) || (exp_bb[2] > exp_bb[3]);
    exp_rast = !bb_bad && (exp_area != 0);
    for (int i = 0; i < 3; i++) begin
      j = (i + 1) % 3;
      k = (i + 2) % 3;
      exp_a[i] = ty[j] - ty[k];
      exp_b[i] = tx[k] - tx[j];
      exp_c[i] = tx[j]*ty[k] - tx[k]*ty[j];
      if (exp_area < 0) begin
        exp_a[i] = -exp_a[i]; exp_b[i] = -exp_b[i]; exp_c[i] = -exp_c[i];
      end
    end
  endtask

  task automatic drive_verts();
    vx1 = 9'(tx[0]); vx2 = 9'(tx[1]); vx3 = 9'(tx[2]);
    vy1 = 8'(ty[0]); vy2 = 8'(ty[1]); vy3 = 8'(ty[2]);
    vz1 = 16'($urandom); vz2 = 16'($urandom); vz3 = 16'($urandom);
    color_in = 8'($urandom); inv_area_in = $urandom;
    tz[0] = vz1; tz[1] = vz2; tz[2] = vz3; tcol = color_in; tinv = inv_area_in;
  endtask

  // Sends one triangle and records what the DUT did; edges are counted from the capture edge.
  task automatic do_tri(input int done_delay, input bit spurious);
    bit rd_sent = 0;
    drive_verts();
    model();
    tri_valid = 1'b1;
    for (int w = 0; w < 50 && !tri_ready; w++) begin @(posedge clk); #1; end
    if (!tri_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout: tri_ready=%0b required 1", tri_ready);
    end
    @(posedge clk); #1;
    tri_valid = 1'b0;
    start_cyc = -1; n_start = 0; got_done = 0; done_cyc = -1;
    for (int cyc = 1; cyc <= 60 && !got_done; cyc++) begin
      @(posedge clk); #1;
      rasterizer_done = 1'b0;
      if (rasterizer_start) begin
        n_start++;
        if (start_cyc < 0) begin
          start_cyc = cyc;
          sa[0] = a1; sa[1] = a2; sa[2] = a3; sb[0] = b1; sb[1] = b2; sb[2] = b3;
          sc[0] = c1; sc[1] = c2; sc[2] = c3;
          sbb[0] = bbxi; sbb[1] = bbxf; sbb[2] = bbyi; sbb[3] = bbyf;
          sz[0] = z1; sz[1] = z2; sz[2] = z3; scol = color; sinv = inv_area;
          cul_at_start = culled;
        end
      end
      if (spurious && cyc == 2) rasterizer_done = 1'b1;
      if (start_cyc > 0 && !rd_sent && cyc == start_cyc + done_delay) begin
        rasterizer_done = 1'b1; rd_sent = 1;
      end
      if (setup_done) begin
        got_done = 1; done_cyc = cyc; cul_at_done = culled;
        da[0] = a1; da[1] = a2; da[2] = a3; db[0] = b1; db[1] = b2; db[2] = b3;
        dc[0] = c1; dc[1] = c2; dc[2] = c3;
        dbb[0] = bbxi; dbb[1] = bbxf; dbb[2] = bbyi; dbb[3] = bbyf;
      end
    end
    rasterizer_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (tri_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %0b required 0", tri_ready); end
    n_cmp++; if ({a1, b3, c1, c3} !== '0) begin n_bad++; $display("FAIL reset_coef: got a1=%0d b3=%0d c1=%0d c3=%0d required 0", a1, b3, c1, c3); end
    n_cmp++; if ({bbxi, bbxf, bbyi, bbyf} !== '0) begin n_bad++; $display("FAIL reset_bbox: got %0d %0d %0d %0d required 0", bbxi, bbxf, bbyi, bbyf); end
    n_cmp++; if ({z1, z3, color, inv_area, rasterizer_start, setup_done, culled} !== '0) begin
      n_bad++; $display("FAIL reset_misc: z1=%0d color=%0d inv=%0h start=%0b done=%0b culled=%0b required 0",
                        z1, color, inv_area, rasterizer_start, setup_done, culled);
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (tri_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %0b required 1", tri_ready); end
  endtask

  task automatic test_basic();
    tx = '{10, 50, 10}; ty = '{10, 10, 50};
    do_tri(2, 0);
    n_cmp++; if (start_cyc != 6) begin n_bad++; $display("FAIL basic_start_cycle: got %0d required 6", start_cyc); end
    n_cmp++; if (n_start != 1) begin n_bad++; $display("FAIL basic_start_count: got %0d required 1", n_start); end
    n_cmp++; if (sa[0] != -40 || sb[0] != -40 || sc[0] != 2400) begin
      n_bad++; $display("FAIL basic_edge1: got a1=%0d b1=%0d c1=%0d required -40 -40 2400", sa[0], sb[0], sc[0]);
    end
    n_cmp++; if (sbb[0] != 10 || sbb[1] != 50 || sbb[2] != 10 || sbb[3] != 50) begin
      n_bad++; $display("FAIL basic_bbox: got %0d..%0d/%0d..%0d required 10..50/10..50", sbb[0], sbb[1], sbb[2], sbb[3]);
    end
    n_cmp++; if (cul_at_start !== 1'b0) begin n_bad++; $display("FAIL basic_culled: got %0b required 0", cul_at_start); end
    n_cmp++; if (!got_done) begin n_bad++; $display("FAIL basic_setup_done: got none required pulse"); end
    n_cmp++; if (sz[0] != tz[0] || sz[2] != tz[2] || scol != tcol || sinv !== tinv) begin
      n_bad++; $display("FAIL basic_passthru: z1=%0d z3=%0d col=%0d inv=%0h required %0d %0d %0d %0h",
                        sz[0], sz[2], scol, sinv, tz[0], tz[2], tcol, tinv);
    end
  endtask

  task automatic test_flip();
    tx = '{10, 10, 50}; ty = '{10, 50, 10};
    do_tri(1, 0);
    n_cmp++; if (exp_area != -1600 || start_cyc != 6) begin
      n_bad++; $display("FAIL flip_start: area_model=%0d start_cycle=%0d required -1600 6", exp_area, start_cyc);
    end
    n_cmp++; if (sa[0] != -40 || sb[0] != -40 || sc[0] != 2400) begin
      n_bad++; $display("FAIL flip_edge1: got a1=%0d b1=%0d c1=%0d required -40 -40 2400", sa[0], sb[0], sc[0]);
    end
    for (int i = 1; i < 3; i++) begin
      n_cmp++; if (sa[i] != exp_a[i] || sb[i] != exp_b[i] || sc[i] != exp_c[i]) begin
        n_bad++; $display("FAIL flip_edge%0d: got %0d %0d %0d required %0d %0d %0d", i+1, sa[i], sb[i], sc[i], exp_a[i], exp_b[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_collinear();
    tx = '{0, 10, 20}; ty = '{0, 10, 20};
    do_tri(1, 1);
    n_cmp++; if (n_start != 0) begin n_bad++; $display("FAIL collinear_start: got %0d pulses required 0", n_start); end
    n_cmp++; if (!got_done || cul_at_done !== 1'b1) begin
      n_bad++; $display("FAIL collinear_done: done=%0b culled=%0b required 1 1", got_done, cul_at_done);
    end
    tx = '{330, 400, 330}; ty = '{10, 10, 50};
    do_tri(1, 0);
    n_cmp++; if (n_start != 0 || !got_done || cul_at_done !== 1'b1) begin
      n_bad++; $display("FAIL offscreen_cull: starts=%0d done=%0b culled=%0b required 0 1 1", n_start, got_done, cul_at_done);
    end
  endtask

  task automatic test_clamp();
    tx = '{400, 100, 150}; ty = '{20, 30, 250};
    do_tri(3, 1);
    n_cmp++; if (sbb[1] != 319 || sbb[3] != 239) begin
      n_bad++; $display("FAIL clamp_max: got bbxf=%0d bbyf=%0d required 319 239", sbb[1], sbb[3]);
    end
    n_cmp++; if (sbb[0] != 100 || sbb[2] != 20 || start_cyc != 6) begin
      n_bad++; $display("FAIL clamp_min: got bbxi=%0d bbyi=%0d start=%0d required 100 20 6", sbb[0], sbb[2], start_cyc);
    end
  endtask

  task automatic test_back_to_back();
    int a_first, c_first, w;
    tx = '{20, 80, 20}; ty = '{20, 20, 90};
    drive_verts(); model();
    a_first = exp_a[0]; c_first = exp_c[0];
    tri_valid = 1'b1;
    for (w = 0; w < 50 && !tri_ready; w++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    tx = '{5, 5, 60}; ty = '{5, 70, 5};
    drive_verts(); model();
    w = 0;
    while (!rasterizer_start && w < 30) begin @(posedge clk); #1; w++; end
    n_cmp++; if (!rasterizer_start) begin n_bad++; $display("FAIL b2b_start_timeout: start=%0b required 1", rasterizer_start); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (tri_ready !== 1'b0 || a1 != a_first || c1 != c_first) begin
        n_bad++; $display("FAIL b2b_hold: ready=%0b a1=%0d c1=%0d required 0 %0d %0d", tri_ready, a1, c1, a_first, c_first);
      end
    end
    rasterizer_done = 1'b1; @(posedge clk); #1; rasterizer_done = 1'b0;
    w = 0;
    while (!setup_done && w < 10) begin @(posedge clk); #1; w++; end
    n_cmp++; if (!setup_done) begin n_bad++; $display("FAIL b2b_done_timeout: setup_done=%0b required 1", setup_done); end
    w = 0;
    while (!rasterizer_start && w < 30) begin @(posedge clk); #1; w++; end
    tri_valid = 1'b0;
    n_cmp++; if (!rasterizer_start || a1 != exp_a[0] || b1 != exp_b[0] || c1 != exp_c[0] || z2 != tz[1]) begin
      n_bad++; $display("FAIL b2b_second: start=%0b a1=%0d b1=%0d c1=%0d z2=%0d required 1 %0d %0d %0d %0d",
                        rasterizer_start, a1, b1, c1, z2, exp_a[0], exp_b[0], exp_c[0], tz[1]);
    end
    @(posedge clk); #1;
    rasterizer_done = 1'b1; @(posedge clk); #1; rasterizer_done = 1'b0;
    w = 0;
    while (!setup_done && w < 10) begin @(posedge clk); #1; w++; end
    n_cmp++; if (!setup_done) begin n_bad++; $display("FAIL b2b_second_done: setup_done=%0b required 1", setup_done); end
  endtask

  task automatic test_reset_wait();
    int w;
    bit saw_done = 0;
    tx = '{30, 90, 30}; ty = '{30, 30, 100};
    drive_verts(); model();
    tri_valid = 1'b1;
    for (w = 0; w < 50 && !tri_ready; w++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    tri_valid = 1'b0;
    w = 0;
    while (!rasterizer_start && w < 30) begin @(posedge clk); #1; w++; end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    n_cmp++; if ({a1, b1, c1, c2, bbxf, bbyf, z1, color, inv_area} !== '0 || tri_ready !== 1'b0 || culled !== 1'b0) begin
      n_bad++; $display("FAIL rstwait_zero: a1=%0d c1=%0d bbxf=%0d z1=%0d inv=%0h ready=%0b required all 0",
                        a1, c1, bbxf, z1, inv_area, tri_ready);
    end
    @(posedge clk); #3;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (setup_done) saw_done = 1;
    end
    n_cmp++; if (saw_done) begin n_bad++; $display("FAIL rstwait_no_done: setup_done seen=1 required 0"); end
    n_cmp++; if (tri_ready !== 1'b1) begin n_bad++; $display("FAIL rstwait_ready: got %0b required 1", tri_ready); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      if (t % 2 == 0) begin
        for (int i = 0; i < 3; i++) begin tx[i] = $urandom_range(0, 319); ty[i] = $urandom_range(0, 239); end
      end else begin
        for (int i = 0; i < 3; i++) begin tx[i] = $urandom_range(0, 511); ty[i] = $urandom_range(0, 255); end
      end
      do_tri($urandom_range(1, 4), t % 3 == 0);
      n_cmp++; if ((n_start == 1) != exp_rast || n_start > 1) begin
        n_bad++; $display("FAIL rnd%0d_start: pulses=%0d required rasterize=%0b area=%0d", t, n_start, exp_rast, exp_area);
      end
      n_cmp++; if (!got_done || cul_at_done !== !exp_rast) begin
        n_bad++; $display("FAIL rnd%0d_cull: done=%0b culled=%0b required 1 %0b", t, got_done, cul_at_done, !exp_rast);
      end
      if (exp_rast && n_start == 1) begin
        n_cmp++; if (start_cyc != 6 || cul_at_start !== 1'b0) begin
          n_bad++; $display("FAIL rnd%0d_latency: start=%0d culled=%0b required 6 0", t, start_cyc, cul_at_start);
        end
        for (int i = 0; i < 3; i++) begin
          n_cmp++; if (sa[i] != exp_a[i] || sb[i] != exp_b[i] || sc[i] != exp_c[i]) begin
            n_bad++; $display("FAIL rnd%0d_edge%0d: got %0d %0d %0d required %0d %0d %0d", t, i+1, sa[i], sb[i], sc[i], exp_a[i], exp_b[i], exp_c[i]);
          end
        end
        for (int i = 0; i < 4; i++) begin
          n_cmp++; if (sbb[i] != exp_bb[i] || dbb[i] != exp_bb[i]) begin
            n_bad++; $display("FAIL rnd%0d_bbox%0d: got %0d at start %0d at done required %0d", t, i, sbb[i], dbb[i], exp_bb[i]);
          end
        end
        n_cmp++; if (da[0] != sa[0] || db[1] != sb[1] || dc[2] != sc[2]) begin
          n_bad++; $display("FAIL rnd%0d_stable: a1=%0d b2=%0d c3=%0d at done required %0d %0d %0d", t, da[0], db[1], dc[2], sa[0], sb[1], sc[2]);
        end
        n_cmp++; if (sz[1] != tz[1] || scol != tcol || sinv !== tinv) begin
          n_bad++; $display("FAIL rnd%0d_passthru: z2=%0d col=%0d inv=%0h required %0d %0d %0h", t, sz[1], scol, sinv, tz[1], tcol, tinv);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flip();
    test_collinear();
    test_clamp();
    test_back_to_back();
    test_reset_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/triangle_setup.md
TRIANGLE_SETUP -- requirements
Module: triangle_setup

Interface
REQ-001 Parameter SCREEN_W, default 320: framebuffer width in pixels.
REQ-002 Parameter SCREEN_H, default 240: framebuffer height in pixels.
REQ-003 Parameter CULL_BACKFACE, default 0: 1 culls negative-area triangles; 0 flips them.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 tri_valid / tri_ready  in / out  1 each  triangle handshake; transfer when both are high on a rising edge.
REQ-007 vx1, vx2, vx3  in  9 each  unsigned vertex x.
REQ-008 vy1, vy2, vy3  in  8 each  unsigned vertex y.
REQ-009 vz1, vz2, vz3  in  16 each  vertex screen-space z.
REQ-010 color_in  in  8  triangle colour.
REQ-011 inv_area_in  in  32  inverse area from the host, passed through.
REQ-012 a1, b1, a2, b2, a3, b3  out  10 each  signed edge coefficients.
REQ-013 c1, c2, c3  out  18 each  signed edge constants.
REQ-014 bbxi, bbxf  out  9 each  bounding box x; bbyi, bbyf  out  8 each  bounding box y.
REQ-015 z1, z2, z3 (16), color (8), inv_area (32)  out  registered copies of the captured inputs.
REQ-016 rasterizer_start  out  1  one-cycle start pulse to the rasterizer.
REQ-017 rasterizer_done  in  1  one-cycle completion pulse from the rasterizer.
REQ-018 setup_done  out  1  one-cycle pulse when the triangle is retired.
REQ-019 culled  out  1  high when the last triangle was not rasterized.

Function
REQ-020 States SHALL be IDLE, EDGE, CEQ, AREA_MUL, AREA, ORIENT, START, WAIT_R, DONE.
REQ-021 IDLE SHALL hold tri_ready=1, capture all inputs on handshake, then go to EDGE; tri_ready SHALL be 0 in all other states.
REQ-022 Edge i SHALL be opposite vertex i: edge1 v2->v3, edge2 v3->v1, edge3 v1->v2.
REQ-023 EDGE SHALL compute, for edge vj->vk: a=yj-yk, b=xk-xj, and register the products xj*yk and xk*yj.
REQ-024 CEQ SHALL compute c=xj*yk-xk*yj; bbxi/bbxf SHALL be the min/max of vx, and bbyi/bbyf the min/max of vy.
REQ-025 CEQ SHALL clamp bbxf to SCREEN_W-1 and bbyf to SCREEN_H-1; if a clamped min exceeds its max, the triangle SHALL be culled.
REQ-026 AREA_MUL/AREA SHALL compute area2 = a1*vx1 + b1*vy1 + c1 as a 21-bit signed value.
REQ-027 ORIENT, area2>0: go to START unchanged.
REQ-028 ORIENT, area2<0 and CULL_BACKFACE=0: negate every a, b, c, then go to START.
REQ-029 ORIENT, area2<0 with CULL_BACKFACE=1, or area2=0: set culled=1 and go directly to DONE.
REQ-030 START SHALL assert rasterizer_start for exactly one cycle, 6 cycles after the capture edge, with culled=0.
REQ-031 WAIT_R SHALL wait for rasterizer_done, then go to DONE; rasterizer_done seen in any other state SHALL be ignored.
REQ-032 DONE SHALL pulse setup_done for one cycle, then return to IDLE.
REQ-033 All coefficient, bbox and pass-through outputs SHALL stay stable from START until the next capture.
REQ-034 All arithmetic SHALL be signed, with zero-extended coordinates, and SHALL not overflow for in-range vertices.

Reset
REQ-035 While rst=0, state SHALL be IDLE and every output SHALL be 0, except tri_ready=1 after reset release.
REQ-036 Reset during WAIT_R SHALL abandon the triangle, with no setup_done pulse.

Structure
REQ-037 Package gpu_pkg SHALL hold SCREEN_W/H defaults, coordinate and coefficient widths, and the setup state enum typedef.
REQ-038 Sub-module edge_coeff SHALL compute one edge's a, b, c (products registered) and SHALL be instantiated three times.

Verification
REQ-039 (10,10),(50,10),(10,50) -> a1=-40, b1=-40, c1=2400, bbox 10..50/10..50, start pulse at cycle 6, culled=0.
REQ-040 v2 and v3 swapped, CULL_BACKFACE=0 -> area2=-1600, flipped; a1=-40, b1=-40, c1=2400.
REQ-041 Collinear (0,0),(10,10),(20,20) -> no rasterizer_start, culled=1, setup_done pulses.
REQ-042 vx1=400, vy3=250 -> bbxf=319, bbyf=239.
REQ-043 tri_valid held during WAIT_R -> tri_ready=0, no capture; rasterizer_done -> setup_done, then capture.
REQ-044 rst low in WAIT_R -> outputs zero, no setup_done, tri_ready=1 after release.
